// File: rtl/dds_iq_if.sv
// Sample-stream bus for the quadrature DDS: control/config in, I/Q samples out.
interface dds_iq_if #(
  parameter int unsigned PW = 32,
  parameter int unsigned DW = 12
);
  logic                 en;
  logic                 cfg_load;
  logic [PW-1:0]        freq_in;
  logic [PW-1:0]        phase_in;
  logic                 phase_clr;
  logic                 out_valid;
  logic signed [DW-1:0] sin_out;
  logic signed [DW-1:0] cos_out;

  modport master (
    output en, cfg_load, freq_in, phase_in, phase_clr,
    input  out_valid, sin_out, cos_out
  );

  modport slave (
    input  en, cfg_load, freq_in, phase_in, phase_clr,
    output out_valid, sin_out, cos_out
  );
endinterface

// File: rtl/dds_iq.sv
// Quadrature DDS: phase accumulator + quarter-wave sine table, three-stage
// pipeline advanced by en, producing simultaneous sine and cosine samples.
module dds_iq #(
  parameter int unsigned PW = 32,
  parameter int unsigned DW = 12,
  parameter int unsigned AW = 10
) (
  input  logic     clk,
  input  logic     rst,
  dds_iq_if.slave  bus
);

  localparam int unsigned Q   = 1 << AW;
  localparam int unsigned MW  = AW + 2;
  localparam int unsigned AMP = (1 << (DW - 1)) - 1;
  localparam real         HALF_PI = 1.5707963267948966;

  // Table entry k = round(sin(pi/2*(k+0.5)/Q) * AMP); evaluated at elaboration
  // with a Taylor series so the result does not depend on tool math folding.
  function automatic logic [DW-1:0] tbl_entry(input int unsigned k);
    real x;
    real term;
    real s;
    x    = HALF_PI * (real'(k) + 0.5) / real'(Q);
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return DW'($rtoi(s * real'(AMP) + 0.5));
  endfunction

  logic [DW-1:0] tbl [Q];

  for (genvar k = 0; k < Q; k++) begin : g_tbl
    localparam logic [DW-1:0] TV = tbl_entry(k);
    assign tbl[k] = TV;
  end

  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] freq_q;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] ph_d;
  logic [MW-1:0] m_q, m_d;
  logic [1:0]    quad_d, quad_c_d;
  logic [AW-1:0] idx_d;
  logic [AW-1:0] sin_addr_d, cos_addr_d;
  logic          sin_neg_q, sin_neg_d;
  logic          cos_neg_q, cos_neg_d;
  logic [DW-1:0] sin_t_q, cos_t_q;
  logic [DW-1:0] sin_q, sin_d;
  logic [DW-1:0] cos_q, cos_d;
  logic [2:0]    vld_q, vld_d;

  // Next-state: accumulator, phase truncation, quadrant folding, output sign.
  always_comb begin
    acc_d = acc_q;
    if (bus.en) begin
      acc_d = acc_q + freq_q;
    end
    if (bus.phase_clr) begin
      acc_d = '0;
    end

    ph_d = acc_q + phase_q;
    m_d  = MW'(ph_d >> (PW - MW));

    quad_d   = m_q[MW-1:AW];
    idx_d    = m_q[AW-1:0];
    quad_c_d = quad_d + 2'd1;

    // Odd quadrants read the table mirrored: ~idx == Q-1-idx.
    sin_addr_d = quad_d[0]   ? ~idx_d : idx_d;
    cos_addr_d = quad_c_d[0] ? ~idx_d : idx_d;
    sin_neg_d  = quad_d[1];
    cos_neg_d  = quad_c_d[1];

    sin_d = sin_neg_q ? (DW'(0) - sin_t_q) : sin_t_q;
    cos_d = cos_neg_q ? (DW'(0) - cos_t_q) : cos_t_q;

    vld_d = {vld_q[1:0], 1'b1};
  end

  // State: shadow config regs load freely; pipeline advances only on en.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      freq_q    <= '0;
      phase_q   <= '0;
      m_q       <= '0;
      sin_t_q   <= '0;
      cos_t_q   <= '0;
      sin_neg_q <= 1'b0;
      cos_neg_q <= 1'b0;
      sin_q     <= '0;
      cos_q     <= '0;
      vld_q     <= '0;
    end else begin
      acc_q <= acc_d;
      if (bus.cfg_load) begin
        freq_q  <= bus.freq_in;
        phase_q <= bus.phase_in;
      end
      if (bus.en) begin
        m_q       <= m_d;
        sin_t_q   <= tbl[sin_addr_d];
        cos_t_q   <= tbl[cos_addr_d];
        sin_neg_q <= sin_neg_d;
        cos_neg_q <= cos_neg_d;
        sin_q     <= sin_d;
        cos_q     <= cos_d;
        vld_q     <= vld_d;
      end
    end
  end

  assign bus.out_valid = vld_q[2];
  assign bus.sin_out   = sin_q;
  assign bus.cos_out   = cos_q;

endmodule

// File: tb/tb_dds_iq.sv
// Directed bench for dds_iq: quarter-rate sequences, config/clear timing,
// en stalls with wrap-around against a libm-based sine reference.
module tb_dds_iq;

  localparam int unsigned PW = 32;
  localparam int unsigned DW = 12;
  localparam int unsigned AW = 10;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dds_iq_if #(.PW(PW), .DW(DW)) bus ();

  dds_iq #(.PW(PW), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int base_sin [4] = '{2, 2047, -2, -2047};
  int base_cos [4] = '{2047, -2, -2047, 2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.cfg_load  = 1'b0;
    bus.phase_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [PW-1:0] f, input logic [PW-1:0] p);
    bus.en       = 1'b0;
    bus.cfg_load = 1'b1;
    bus.freq_in  = f;
    bus.phase_in = p;
    tick();
    bus.cfg_load = 1'b0;
  endtask

  // Reference sample for 12-bit full-circle phase m (rounded magnitude, signed).
  function automatic int ref_val(input int m, input bit is_cos);
    real a;
    real v;
    int  r;
    a = 2.0 * PI * (real'(m) + 0.5) / 4096.0;
    v = 2047.0 * (is_cos ? $cos(a) : $sin(a));
    r = $rtoi(((v < 0.0) ? -v : v) + 0.5);
    return (v < 0.0) ? -r : r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.sin_out !== 12'sd0) begin
      miscompares++;
      $display("FAIL reset_sin got %0d want 0", bus.sin_out);
    end
    vectors++;
    if (bus.cos_out !== 12'sd0) begin
      miscompares++;
      $display("FAIL reset_cos got %0d want 0", bus.cos_out);
    end
    bus.en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_static();
    do_reset();
    load('0, '0);
    bus.en = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'(e >= 3)) begin
        miscompares++;
        $display("FAIL static_valid e=%0d got %b want %b", e, bus.out_valid, e >= 3);
      end
      if (e >= 3) begin
        vectors++;
        if (bus.sin_out !== 12'sd2) begin
          miscompares++;
          $display("FAIL static_sin e=%0d got %0d want 2", e, bus.sin_out);
        end
        vectors++;
        if (bus.cos_out !== 12'sd2047) begin
          miscompares++;
          $display("FAIL static_cos e=%0d got %0d want 2047", e, bus.cos_out);
        end
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_quarter();
    logic signed [DW-1:0] es, ec;
    do_reset();
    load(32'h4000_0000, '0);
    bus.en = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'(e >= 3)) begin
        miscompares++;
        $display("FAIL quarter_valid e=%0d got %b want %b", e, bus.out_valid, e >= 3);
      end
      if (e >= 3) begin
        es = DW'(base_sin[(e - 3) % 4]);
        ec = DW'(base_cos[(e - 3) % 4]);
        vectors++;
        if (bus.sin_out !== es) begin
          miscompares++;
          $display("FAIL quarter_sin e=%0d got %0d want %0d", e, bus.sin_out, es);
        end
        vectors++;
        if (bus.cos_out !== ec) begin
          miscompares++;
          $display("FAIL quarter_cos e=%0d got %0d want %0d", e, bus.cos_out, ec);
        end
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_phase_shift();
    logic signed [DW-1:0] es, ec;
    int s;
    do_reset();
    load(32'h4000_0000, '0);
    bus.phase_in = 32'h8000_0000;
    bus.en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      bus.cfg_load = (e == 6);
      tick();
      bus.cfg_load = 1'b0;
      if (e >= 3) begin
        s  = e - 3;
        es = DW'((s > 5) ? -base_sin[s % 4] : base_sin[s % 4]);
        ec = DW'((s > 5) ? -base_cos[s % 4] : base_cos[s % 4]);
        vectors++;
        if (bus.sin_out !== es) begin
          miscompares++;
          $display("FAIL pshift_sin s=%0d got %0d want %0d", s, bus.sin_out, es);
        end
        vectors++;
        if (bus.cos_out !== ec) begin
          miscompares++;
          $display("FAIL pshift_cos s=%0d got %0d want %0d", s, bus.cos_out, ec);
        end
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_freq_load();
    logic signed [DW-1:0] es, ec;
    int s;
    do_reset();
    load(32'h4000_0000, '0);
    bus.freq_in  = '0;
    bus.phase_in = '0;
    bus.en = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      bus.cfg_load = (e == 3);
      tick();
      bus.cfg_load = 1'b0;
      if (e >= 3) begin
        s  = e - 3;
        es = DW'(base_sin[(s < 3) ? s : 3]);
        ec = DW'(base_cos[(s < 3) ? s : 3]);
        vectors++;
        if (bus.sin_out !== es) begin
          miscompares++;
          $display("FAIL fload_sin s=%0d got %0d want %0d", s, bus.sin_out, es);
        end
        vectors++;
        if (bus.cos_out !== ec) begin
          miscompares++;
          $display("FAIL fload_cos s=%0d got %0d want %0d", s, bus.cos_out, ec);
        end
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_phase_clr();
    logic signed [DW-1:0] es, ec;
    int s, k;
    do_reset();
    load(32'h4000_0000, '0);
    bus.en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      bus.phase_clr = (e == 6);
      tick();
      bus.phase_clr = 1'b0;
      if (e >= 3) begin
        s  = e - 3;
        k  = (s < 6) ? (s % 4) : ((s - 6) % 4);
        es = DW'(base_sin[k]);
        ec = DW'(base_cos[k]);
        vectors++;
        if (bus.sin_out !== es) begin
          miscompares++;
          $display("FAIL pclr_sin s=%0d got %0d want %0d", s, bus.sin_out, es);
        end
        vectors++;
        if (bus.cos_out !== ec) begin
          miscompares++;
          $display("FAIL pclr_cos s=%0d got %0d want %0d", s, bus.cos_out, ec);
        end
      end
    end
    bus.en = 1'b0;
  endtask

  // Clear and load together in an en=0 cycle: next sample uses acc=0, new phase.
  task automatic test_clr_load();
    logic signed [DW-1:0] es, ec;
    int  n, s, k;
    logic idle;
    do_reset();
    load(32'h4000_0000, '0);
    bus.phase_in = 32'h4000_0000;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      idle          = (c == 5);
      bus.en        = !idle;
      bus.phase_clr = idle;
      bus.cfg_load  = idle;
      tick();
      bus.phase_clr = 1'b0;
      bus.cfg_load  = 1'b0;
      if (!idle) n++;
      vectors++;
      if (bus.out_valid !== 1'(n >= 3)) begin
        miscompares++;
        $display("FAIL clrld_valid c=%0d got %b want %b", c, bus.out_valid, n >= 3);
      end
      if (n >= 3) begin
        s  = n - 3;
        k  = (s < 5) ? (s % 4) : ((s - 4) % 4);
        es = DW'(base_sin[k]);
        ec = DW'(base_cos[k]);
        vectors++;
        if (bus.sin_out !== es) begin
          miscompares++;
          $display("FAIL clrld_sin c=%0d got %0d want %0d", c, bus.sin_out, es);
        end
        vectors++;
        if (bus.cos_out !== ec) begin
          miscompares++;
          $display("FAIL clrld_cos c=%0d got %0d want %0d", c, bus.cos_out, ec);
        end
      end
    end
    bus.en = 1'b0;
  endtask

  // freq = 2^20 steps the 12-bit phase by one per sample; 4200 samples wrap 2^32.
  task automatic test_en_gaps();
    logic signed [DW-1:0] es, ec;
    int n, m;
    do_reset();
    load(32'h0010_0000, '0);
    n = 0;
    for (int c = 0; c < 20000 && n < 4200; c++) begin
      bus.en = ($urandom_range(0, 3) != 0);
      tick();
      if (bus.en) n++;
      vectors++;
      if (bus.out_valid !== 1'(n >= 3)) begin
        miscompares++;
        $display("FAIL gaps_valid c=%0d got %b want %b", c, bus.out_valid, n >= 3);
      end
      if (n >= 3) begin
        m  = (n - 3) % 4096;
        es = DW'(ref_val(m, 1'b0));
        ec = DW'(ref_val(m, 1'b1));
        vectors++;
        if (bus.sin_out !== es) begin
          miscompares++;
          $display("FAIL gaps_sin c=%0d m=%0d got %0d want %0d", c, m, bus.sin_out, es);
        end
        vectors++;
        if (bus.cos_out !== ec) begin
          miscompares++;
          $display("FAIL gaps_cos c=%0d m=%0d got %0d want %0d", c, m, bus.cos_out, ec);
        end
      end
    end
    vectors++;
    if (n < 4200) begin
      miscompares++;
      $display("FAIL gaps_budget pushed %0d want 4200", n);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(32'h4000_0000, '0);
    bus.en = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_valid got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.sin_out !== 12'sd0) begin
      miscompares++;
      $display("FAIL rstmid_sin got %0d want 0", bus.sin_out);
    end
    vectors++;
    if (bus.cos_out !== 12'sd0) begin
      miscompares++;
      $display("FAIL rstmid_cos got %0d want 0", bus.cos_out);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'(e >= 3)) begin
        miscompares++;
        $display("FAIL rstmid_revalid e=%0d got %b want %b", e, bus.out_valid, e >= 3);
      end
    end
    vectors++;
    if (bus.sin_out !== 12'sd2 || bus.cos_out !== 12'sd2047) begin
      miscompares++;
      $display("FAIL rstmid_sample got %0d/%0d want 2/2047", bus.sin_out, bus.cos_out);
    end
    bus.en = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.cfg_load  = 1'b0;
    bus.phase_clr = 1'b0;
    bus.freq_in   = '0;
    bus.phase_in  = '0;
    test_reset();
    test_static();
    test_quarter();
    test_phase_shift();
    test_freq_load();
    test_phase_clr();
    test_clr_load();
    test_en_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
